// File: rtl/msrv32_pkg.sv
// Shared RV32 definitions: XLEN, load/store size encodings, LSU state encoding
// and the alignment rule used for memory accesses.
package msrv32_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

    // Reserved size 2'b11 follows the word rule.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LS_BYTE: mis = 1'b0;
            LS_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_lsu_align.sv
// Combinational lane logic: store byte-mask / lane-replicated write data, and
// load byte/half extraction with sign or zero extension.
module msrv32_lsu_align
    import msrv32_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      st_mask,
    output logic [XLEN-1:0] st_wdata,
    input  logic [1:0]      ld_size,
    input  logic [1:0]      ld_off,
    input  logic            ld_unsigned,
    input  logic [XLEN-1:0] ld_rdata,
    output logic [XLEN-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_mask  = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            LS_BYTE: begin
                st_mask  = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            LS_HALF: begin
                st_mask  = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_rdata[7:0];
        case (ld_off)
            2'd1:    ld_byte = ld_rdata[15:8];
            2'd2:    ld_byte = ld_rdata[23:16];
            2'd3:    ld_byte = ld_rdata[31:24];
            default: ;
        endcase
        ld_half = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = ld_rdata;
        case (ld_size)
            LS_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            LS_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu.sv
// Load/store unit: one req/ack data-bus transaction at a time, pipeline stall
// while in flight, misalignment reporting without a bus request, and a bus timeout.
module msrv32_lsu
    import msrv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            mem_op_valid_in,
    input  logic            is_store_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data_in,
    input  logic [1:0]      size_in,
    input  logic            load_unsigned_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush_in,
    output logic            dbus_req_out,
    output logic            dbus_we_out,
    output logic [XLEN-1:0] dbus_addr_out,
    output logic [XLEN-1:0] dbus_wdata_out,
    output logic [3:0]      dbus_wmask_out,
    input  logic            dbus_ack_in,
    input  logic [XLEN-1:0] dbus_rdata_in,
    output logic            stall_out,
    output logic            load_valid_out,
    output logic [XLEN-1:0] load_data_out,
    output logic [4:0]      load_rd_addr_out,
    output logic            misaligned_out,
    output logic            misaligned_store_out,
    output logic [XLEN-1:0] misaligned_addr_out,
    output logic            bus_error_out
);

    localparam int       CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e      state, state_n;
    logic [29:0]     word_addr_q;
    logic            we_q, unsigned_q, squash_q;
    logic [3:0]      mask_q;
    logic [XLEN-1:0] wdata_q;
    logic [1:0]      off_q, size_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   tcount;

    logic            busy, can_accept, accept_now, misalign_now, timeout_now;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_wdata, ld_data;

    msrv32_lsu_align u_align (
        .st_size     (size_in),
        .st_off      (addr_in[1:0]),
        .st_data     (store_data_in),
        .st_mask     (st_mask),
        .st_wdata    (st_wdata),
        .ld_size     (size_q),
        .ld_off      (off_q),
        .ld_unsigned (unsigned_q),
        .ld_rdata    (dbus_rdata_in),
        .ld_data     (ld_data)
    );

    assign busy         = (state == BUSY);
    assign can_accept   = !busy && mem_op_valid_in && !flush_in;
    assign accept_now   = can_accept && !is_misaligned(size_in, addr_in[1:0]);
    assign misalign_now = can_accept && is_misaligned(size_in, addr_in[1:0]);
    // An ack in the same cycle as the limit is reached wins over the timeout.
    assign timeout_now  = busy && !dbus_ack_in && (TIMEOUT_CYCLES != 0) && (tcount == TLIM);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            BUSY: begin
                if (dbus_ack_in)      state_n = DONE;
                else if (timeout_now) state_n = IDLE;
            end
            default: state_n = accept_now ? BUSY : IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            word_addr_q          <= '0;
            we_q                 <= 1'b0;
            mask_q               <= '0;
            wdata_q              <= '0;
            off_q                <= '0;
            size_q               <= '0;
            unsigned_q           <= 1'b0;
            rd_q                 <= '0;
            squash_q             <= 1'b0;
            tcount               <= '0;
            load_valid_out       <= 1'b0;
            load_data_out        <= '0;
            load_rd_addr_out     <= '0;
            misaligned_out       <= 1'b0;
            misaligned_store_out <= 1'b0;
            misaligned_addr_out  <= '0;
            bus_error_out        <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            if (accept_now) begin
                word_addr_q <= addr_in[31:2];
                we_q        <= is_store_in;
                mask_q      <= is_store_in ? st_mask : 4'b0000;
                wdata_q     <= is_store_in ? st_wdata : '0;
                off_q       <= addr_in[1:0];
                size_q      <= size_in;
                unsigned_q  <= load_unsigned_in;
                rd_q        <= rd_addr_in;
                squash_q    <= 1'b0;
                tcount      <= '0;
            end
            if (misalign_now) begin
                misaligned_out       <= 1'b1;
                misaligned_store_out <= is_store_in;
                misaligned_addr_out  <= addr_in;
            end
            if (busy) begin
                // A flush never withdraws the request; it only suppresses load writeback.
                if (flush_in) squash_q <= 1'b1;
                if (dbus_ack_in) begin
                    if (!we_q && !squash_q && !flush_in) begin
                        load_valid_out   <= 1'b1;
                        load_data_out    <= ld_data;
                        load_rd_addr_out <= rd_q;
                    end
                end else if (timeout_now) begin
                    bus_error_out <= 1'b1;
                end else begin
                    tcount <= tcount + 1'b1;
                end
            end
        end
    end

    assign dbus_req_out   = busy;
    assign dbus_we_out    = busy && we_q;
    assign dbus_addr_out  = busy ? {word_addr_q, 2'b00} : '0;
    assign dbus_wdata_out = busy ? wdata_q : '0;
    assign dbus_wmask_out = busy ? mask_q : 4'b0000;
    assign stall_out      = busy || accept_now;

endmodule

// File: tb/tb_msrv32_lsu.sv
// Directed plus randomized bench for msrv32_lsu with a byte-lane arithmetic
// reference model and a queue of expected load results.
module tb_msrv32_lsu;

    localparam int TMO = 4;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        mem_op_valid_in = 1'b0;
    logic        is_store_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [31:0] store_data_in = '0;
    logic [1:0]  size_in = '0;
    logic        load_unsigned_in = 1'b0;
    logic [4:0]  rd_addr_in = '0;
    logic        flush_in = 1'b0;
    logic        dbus_ack_in = 1'b0;
    logic [31:0] dbus_rdata_in = '0;
    logic        dbus_req_out, dbus_we_out, stall_out, load_valid_out;
    logic [31:0] dbus_addr_out, dbus_wdata_out, load_data_out, misaligned_addr_out;
    logic [3:0]  dbus_wmask_out;
    logic [4:0]  load_rd_addr_out;
    logic        misaligned_out, misaligned_store_out, bus_error_out;

    msrv32_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .mem_op_valid_in      (mem_op_valid_in),
        .is_store_in          (is_store_in),
        .addr_in              (addr_in),
        .store_data_in        (store_data_in),
        .size_in              (size_in),
        .load_unsigned_in     (load_unsigned_in),
        .rd_addr_in           (rd_addr_in),
        .flush_in             (flush_in),
        .dbus_req_out         (dbus_req_out),
        .dbus_we_out          (dbus_we_out),
        .dbus_addr_out        (dbus_addr_out),
        .dbus_wdata_out       (dbus_wdata_out),
        .dbus_wmask_out       (dbus_wmask_out),
        .dbus_ack_in          (dbus_ack_in),
        .dbus_rdata_in        (dbus_rdata_in),
        .stall_out            (stall_out),
        .load_valid_out       (load_valid_out),
        .load_data_out        (load_data_out),
        .load_rd_addr_out     (load_rd_addr_out),
        .misaligned_out       (misaligned_out),
        .misaligned_store_out (misaligned_store_out),
        .misaligned_addr_out  (misaligned_addr_out),
        .bus_error_out        (bus_error_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [4:0]  rd_exp_q[$];
    bit          pend_lv = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_mask(input bit st, input logic [1:0] sz, input logic [1:0] off);
        if (!st)          return 4'h0;
        if (sz == 2'd0)   return 4'(1 << off);
        if (sz == 2'd1)   return 4'(3 << (off & 2'd2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] sz,
                                             input logic [1:0] off, input bit u);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Called at a negedge: compares the strobe against what the model expects now.
    task automatic check_done();
        check("load_valid", {31'b0, load_valid_out}, {31'b0, pend_lv});
        if (pend_lv) begin
            check("load_data", load_data_out, exp_q.pop_front());
            check("load_rd", {27'b0, load_rd_addr_out}, {27'b0, rd_exp_q.pop_front()});
        end
        pend_lv = 1'b0;
    endtask

    task automatic drive_op(input bit st, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz, input bit u, input logic [4:0] rd);
        mem_op_valid_in  = 1'b1;
        is_store_in      = st;
        addr_in          = a;
        store_data_in    = d;
        size_in          = sz;
        load_unsigned_in = u;
        rd_addr_in       = rd;
    endtask

    // Runs an aligned op already presented on the inputs; w = BUSY cycles before ack.
    task automatic run_txn(input int w, input logic [31:0] rdata, input int flush_at, input bit do_done);
        bit          st = is_store_in;
        logic [31:0] a  = addr_in;
        logic [31:0] d  = store_data_in;
        logic [1:0]  sz = size_in;
        bit          u  = load_unsigned_in;
        logic [4:0]  rd = rd_addr_in;
        @(negedge clk_in);
        check_done();
        check("accept_stall", {31'b0, stall_out}, 32'd1);
        check("accept_req", {31'b0, dbus_req_out}, 32'd0);
        @(posedge clk_in); #1;
        mem_op_valid_in = 1'b0;
        for (int k = 0; k <= w; k++) begin
            dbus_ack_in   = (k == w);
            dbus_rdata_in = (k == w) ? rdata : $urandom;
            flush_in      = (k == flush_at);
            @(negedge clk_in);
            check("busy_req", {31'b0, dbus_req_out}, 32'd1);
            check("busy_stall", {31'b0, stall_out}, 32'd1);
            check("busy_addr", dbus_addr_out, a & 32'hFFFF_FFFC);
            check("busy_we", {31'b0, dbus_we_out}, {31'b0, st});
            check("busy_mask", {28'b0, dbus_wmask_out}, {28'b0, exp_mask(st, sz, a[1:0])});
            if (st) check("busy_wdata", dbus_wdata_out, exp_wdata(sz, d));
            check("busy_lv", {31'b0, load_valid_out}, 32'd0);
            @(posedge clk_in); #1;
            dbus_ack_in = 1'b0;
            flush_in    = 1'b0;
        end
        if (!st && !(flush_at >= 0 && flush_at <= w)) begin
            exp_q.push_back(exp_load(rdata, sz, a[1:0], u));
            rd_exp_q.push_back(rd);
            pend_lv = 1'b1;
        end
        if (do_done) begin
            @(negedge clk_in);
            check_done();
            check("done_stall", {31'b0, stall_out}, 32'd0);
            check("done_req", {31'b0, dbus_req_out}, 32'd0);
            @(posedge clk_in); #1;
        end
    endtask

    task automatic misal_op(input bit st, input logic [31:0] a, input logic [1:0] sz);
        drive_op(st, a, $urandom, sz, 1'b0, 5'd1);
        @(negedge clk_in);
        check_done();
        check("mis_stall", {31'b0, stall_out}, 32'd0);
        check("mis_req", {31'b0, dbus_req_out}, 32'd0);
        @(posedge clk_in); #1;
        mem_op_valid_in = 1'b0;
        @(negedge clk_in);
        check("mis_pulse", {31'b0, misaligned_out}, 32'd1);
        check("mis_store", {31'b0, misaligned_store_out}, {31'b0, st});
        check("mis_addr", misaligned_addr_out, a);
        check("mis_req2", {31'b0, dbus_req_out}, 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("mis_pulse_end", {31'b0, misaligned_out}, 32'd0);
        @(posedge clk_in); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'b0, dbus_req_out}, 32'd0);
        check({tag, "_stall"}, {31'b0, stall_out}, 32'd0);
        check({tag, "_addr"}, dbus_addr_out, 32'd0);
        check({tag, "_mask"}, {28'b0, dbus_wmask_out}, 32'd0);
        check({tag, "_lv"}, {31'b0, load_valid_out}, 32'd0);
        check({tag, "_ldata"}, load_data_out, 32'd0);
        check({tag, "_lrd"}, {27'b0, load_rd_addr_out}, 32'd0);
        check({tag, "_mis"}, {31'b0, misaligned_out}, 32'd0);
        check({tag, "_misaddr"}, misaligned_addr_out, 32'd0);
        check({tag, "_berr"}, {31'b0, bus_error_out}, 32'd0);
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        // word store, signed/unsigned byte load, half store
        drive_op(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, 5'd0);
        run_txn(0, 32'h0, -1, 1'b1);
        drive_op(1'b0, 32'h203, 32'h0, 2'd0, 1'b0, 5'd5);
        run_txn(3, 32'h80FF_FFFF, -1, 1'b1);
        drive_op(1'b0, 32'h203, 32'h0, 2'd0, 1'b1, 5'd6);
        run_txn(3, 32'h80FF_FFFF, -1, 1'b1);
        drive_op(1'b1, 32'h42, 32'h1234_ABCD, 2'd1, 1'b0, 5'd0);
        run_txn(1, 32'h0, -1, 1'b1);

        // misaligned word load
        misal_op(1'b0, 32'h106, 2'd2);

        // flushed load, then back-to-back op in the DONE cycle
        drive_op(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 5'd7);
        run_txn(2, 32'h1122_3344, 0, 1'b0);
        drive_op(1'b0, 32'h306, 32'h0, 2'd1, 1'b0, 5'd8);
        run_txn(0, 32'hCAFE_F00D, -1, 1'b1);

        // timeout with no ack
        drive_op(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 5'd9);
        @(negedge clk_in);
        check("tmo_accept_stall", {31'b0, stall_out}, 32'd1);
        @(posedge clk_in); #1;
        mem_op_valid_in = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk_in);
            check("tmo_req", {31'b0, dbus_req_out}, 32'd1);
            check("tmo_berr_early", {31'b0, bus_error_out}, 32'd0);
            @(posedge clk_in); #1;
        end
        @(negedge clk_in);
        check("tmo_req_drop", {31'b0, dbus_req_out}, 32'd0);
        check("tmo_berr", {31'b0, bus_error_out}, 32'd1);
        check("tmo_stall", {31'b0, stall_out}, 32'd0);
        check("tmo_lv", {31'b0, load_valid_out}, 32'd0);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        check("tmo_berr_end", {31'b0, bus_error_out}, 32'd0);
        @(posedge clk_in); #1;

        // reset in the middle of BUSY
        drive_op(1'b1, 32'h500, 32'h5555_AAAA, 2'd2, 1'b0, 5'd0);
        @(posedge clk_in); #1;
        mem_op_valid_in = 1'b0;
        @(negedge clk_in);
        check("rst_mid_req_before", {31'b0, dbus_req_out}, 32'd1);
        #2;
        reset_in = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk_in);
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a = $urandom;
            logic [1:0]  sz;
            int          w;
            int          fa;
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    sz   = 2'd1;
                    a[0] = 1'b1;
                end else begin
                    sz     = 2'($urandom_range(2, 3));
                    a[1:0] = 2'($urandom_range(1, 3));
                end
                misal_op(1'($urandom_range(0, 1)), a, sz);
            end else begin
                sz = 2'($urandom_range(0, 3));
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz >= 2'd2) a[1:0] = 2'b00;
                w  = $urandom_range(0, 3);
                fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, w) : -1;
                drive_op(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
                         5'($urandom_range(0, 31)));
                run_txn(w, $urandom, fa, 1'($urandom_range(0, 1)));
            end
        end
        @(negedge clk_in);
        check_done();
        @(posedge clk_in); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
